// File: rtl/id_ex_stage.sv
// ID/EX pipeline slot: drives register file reads, bypasses same-edge writeback,
// stalls on load-use, squashes on flush and holds (with writeback snoop) under back-pressure.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_memread,
    input  logic              in_regwrite,
    output logic [4:0]        rf_readreg1,
    output logic [4:0]        rf_readreg2,
    input  logic [XLEN-1:0]   rf_readdata1,
    input  logic [XLEN-1:0]   rf_readdata2,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_memread,
    output logic              out_regwrite
);

    logic            adv;
    logic            hazard;
    logic            wb_hit1;
    logic            wb_hit2;
    logic            snoop1;
    logic            snoop2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign rf_readreg1 = in_rs1;
    assign rf_readreg2 = in_rs2;

    assign adv    = ex_ready | ~out_valid;
    assign hazard = in_valid & out_valid & out_memread & (out_rd != 5'd0) &
                    ((in_use_rs1 & (out_rd == in_rs1)) | (in_use_rs2 & (out_rd == in_rs2)));
    assign in_ready = flush | (adv & ~hazard);

    // Register file reads miss a write on the same edge, so forward the writeback bus.
    assign wb_hit1 = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == in_rs1);
    assign wb_hit2 = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == in_rs2);

    always_comb begin
        op1 = rf_readdata1;
        op2 = rf_readdata2;
        if (in_rs1 == 5'd0)
            op1 = '0;
        else if (wb_hit1)
            op1 = wb_data;
        if (in_rs2 == 5'd0)
            op2 = '0;
        else if (wb_hit2)
            op2 = wb_data;
    end

    // A held slot keeps its operands current with writebacks that land while it waits.
    assign snoop1 = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == out_rs1);
    assign snoop2 = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == out_rs2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_imm      <= '0;
            out_rs1_val  <= '0;
            out_rs2_val  <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rd       <= '0;
            out_ctrl     <= '0;
            out_memread  <= 1'b0;
            out_regwrite <= 1'b0;
        end else if (flush || (adv && hazard)) begin
            out_valid    <= 1'b0;
            out_memread  <= 1'b0;
            out_regwrite <= 1'b0;
        end else if (!adv) begin
            if (snoop1)
                out_rs1_val <= wb_data;
            if (snoop2)
                out_rs2_val <= wb_data;
        end else begin
            out_valid    <= in_valid;
            out_pc       <= in_pc;
            out_imm      <= in_imm;
            out_rs1_val  <= op1;
            out_rs2_val  <= op2;
            out_rs1      <= in_rs1;
            out_rs2      <= in_rs2;
            out_rd       <= in_rd;
            out_ctrl     <= in_ctrl;
            out_memread  <= in_valid & in_memread;
            out_regwrite <= in_valid & in_regwrite;
        end
    end

endmodule
